div_unit: RTL

//  Iterative RV32M divider (DIV/DIVU/REM/REMU). It sits between the register file

---
 rtl/div_unit.sv | 110 +++++++++++
 1 files changed

// File: rtl/div_unit.sv
// div_unit: iterative RV32M divider (DIV/DIVU/REM/REMU), one quotient bit per cycle,
// with divide-by-zero and signed-overflow results produced without iterating.
module div_unit #(
   parameter int XLEN   = 32,
   parameter int ADDR_W = 5
) (
   input  logic              i_clk,
   input  logic              i_reset_n,
   input  logic              i_start,
   input  logic              i_flush,
   input  logic [1:0]        i_op,
   input  logic [XLEN-1:0]   i_rs1_data,
   input  logic [XLEN-1:0]   i_rs2_data,
   input  logic [ADDR_W-1:0] i_rd_addr,
   output logic              o_busy,
   output logic              o_valid,
   output logic [ADDR_W-1:0] o_rd_addr,
   output logic [XLEN-1:0]   o_rd_data,
   output logic              o_rd_wren
);
   localparam int CW = $clog2(XLEN);
   typedef enum logic [1:0] {IDLE, CALC, DONE} state_t;
   state_t            state;
   logic [XLEN-1:0]   rem, quo, dvs;
   logic [CW-1:0]     cnt;
   logic              sel_rem, neg_q, neg_r;
   logic [ADDR_W-1:0] rd;
   logic              sgn, div0, ovf;
   logic [XLEN-1:0]   a_abs, b_abs, spec_res, rem_n, quo_n, res;
   logic [XLEN:0]     rem_sh, diff;
   always_comb begin
      sgn      = ~i_op[0];
      a_abs    = (sgn && i_rs1_data[XLEN-1]) ? -i_rs1_data : i_rs1_data;
      b_abs    = (sgn && i_rs2_data[XLEN-1]) ? -i_rs2_data : i_rs2_data;
      div0     = i_rs2_data == '0;
      ovf      = sgn && i_rs1_data == {1'b1, {(XLEN-1){1'b0}}} && (&i_rs2_data);
      // overflow dividend is the most-negative value, which is also its quotient
      spec_res = div0 ? (i_op[1] ? i_rs1_data : '1) : (i_op[1] ? '0 : i_rs1_data);
      rem_sh   = {rem, quo[XLEN-1]};
      diff     = rem_sh - {1'b0, dvs};
      rem_n    = diff[XLEN] ? rem_sh[XLEN-1:0] : diff[XLEN-1:0];
      quo_n    = {quo[XLEN-2:0], ~diff[XLEN]};
      res      = sel_rem ? (neg_r ? -rem_n : rem_n) : (neg_q ? -quo_n : quo_n);
   end
   always_ff @(posedge i_clk or negedge i_reset_n) begin
      if (!i_reset_n) begin
         state     <= IDLE;
         rem       <= '0;
         quo       <= '0;
         dvs       <= '0;
         cnt       <= '0;
         sel_rem   <= 1'b0;
         neg_q     <= 1'b0;
         neg_r     <= 1'b0;
         rd        <= '0;
         o_busy    <= 1'b0;
         o_valid   <= 1'b0;
         o_rd_addr <= '0;
         o_rd_data <= '0;
         o_rd_wren <= 1'b0;
      end else begin
         o_valid   <= 1'b0;
         o_rd_wren <= 1'b0;
         if (i_flush) begin
            state  <= IDLE;
            o_busy <= 1'b0;
         end else begin
            case (state)
               IDLE: if (i_start) begin
                  sel_rem <= i_op[1];
                  rd      <= i_rd_addr;
                  neg_q   <= sgn & (i_rs1_data[XLEN-1] ^ i_rs2_data[XLEN-1]);
                  neg_r   <= sgn & i_rs1_data[XLEN-1];
                  rem     <= '0;
                  quo     <= a_abs;
                  dvs     <= b_abs;
                  cnt     <= CW'(XLEN-1);
                  o_busy  <= 1'b1;
                  if (div0 || ovf) begin
                     state     <= DONE;
                     o_valid   <= 1'b1;
                     o_rd_wren <= |i_rd_addr;
                     o_rd_addr <= i_rd_addr;
                     o_rd_data <= spec_res;
                  end else begin
                     state <= CALC;
                  end
               end
               CALC: begin
                  rem <= rem_n;
                  quo <= quo_n;
                  cnt <= cnt - CW'(1);
                  if (cnt == '0) begin
                     state     <= DONE;
                     o_valid   <= 1'b1;
                     o_rd_wren <= |rd;
                     o_rd_addr <= rd;
                     o_rd_data <= res;
                  end
               end
               DONE: begin
                  state  <= IDLE;
                  o_busy <= 1'b0;
               end
               default: state <= IDLE;
            endcase
         end
      end
   end
endmodule
